// File: rtl/card_dealer_if.sv
// Request/ready/value handshake between the game controller and the card dealer.
// The controller is the master; the dealer is the slave.
interface card_dealer_if #(
  parameter int DECKS = 1
);
  localparam int LW = $clog2(52 * DECKS + 1);

  logic          request;
  logic          shuffle;
  logic          ready;
  logic [3:0]    value;
  logic          busy;
  logic [LW-1:0] cards_left;

  modport master (
    output request, shuffle,
    input  ready, value, busy, cards_left
  );

  modport slave (
    input  request, shuffle,
    output ready, value, busy, cards_left
  );
endinterface

// File: rtl/card_dealer.sv
// Multi-deck shoe that deals blackjack card values without replacement.
// Cards are picked by LFSR rejection sampling, with a linear scan as the fallback.
//   state   | meaning
//   IDLE    | waiting for a request or a shuffle
//   SHUFFLE | reloading one rank counter per cycle, 13 cycles in total
//   DRAW    | trying LFSR candidates, at most 16 of them
//   SCAN    | walking the ranks to find the first nonempty one
//   DELIVER | ready pulse; value is valid
module card_dealer #(
  parameter int          DECKS = 1,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  card_dealer_if.slave bus
);
  localparam int CW = $clog2(4 * DECKS + 1);
  localparam int LW = $clog2(52 * DECKS + 1);
  localparam logic [CW-1:0] FULL_RANK = CW'(4 * DECKS);
  localparam logic [LW-1:0] FULL_SHOE = LW'(52 * DECKS);
  localparam logic [15:0]   SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {IDLE, SHUFFLE, DRAW, SCAN, DELIVER} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] rank_cnt [13];
  logic [LW-1:0] left;
  logic [15:0]   lfsr;
  logic [3:0]    tries;
  logic [3:0]    ptr;
  logic          req_pending, shuf_pending;
  logic [3:0]    value_q;

  logic [3:0]    cand;
  logic [CW-1:0] cand_cnt, ptr_cnt;
  logic          take;
  logic [3:0]    take_rank;
  logic          req_set, req_clr, shuf_set, shuf_clr;

  function automatic logic [3:0] rank_value(input logic [3:0] r);
    if (r == 4'd0)       return 4'd1;
    else if (r < 4'd10)  return r + 4'd1;
    else                 return 4'd10;
  endfunction

  assign cand = lfsr[3:0];

  // Index by compare so that candidates 13..15 never address the array.
  always_comb begin
    cand_cnt = '0;
    ptr_cnt  = '0;
    for (int i = 0; i < 13; i++) begin
      if (cand == 4'(i)) cand_cnt = rank_cnt[i];
      if (ptr == 4'(i))  ptr_cnt  = rank_cnt[i];
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    take_rank = cand;
    req_set   = 1'b0;
    req_clr   = 1'b0;
    shuf_set  = 1'b0;
    shuf_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.shuffle || shuf_pending) begin
          state_nxt = SHUFFLE;
          shuf_clr  = 1'b1;
          req_set   = bus.request;
        end else if (bus.request || req_pending) begin
          if (left == '0) begin
            state_nxt = SHUFFLE;
            req_set   = 1'b1;
          end else begin
            state_nxt = DRAW;
            req_clr   = 1'b1;
          end
        end
      end
      SHUFFLE: begin
        req_set = bus.request;
        if (ptr == 4'd12) state_nxt = IDLE;
      end
      DRAW: begin
        shuf_set = bus.shuffle;
        if (cand < 4'd13 && cand_cnt != '0) begin
          take      = 1'b1;
          state_nxt = DELIVER;
        end else if (tries == 4'd15) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        shuf_set  = bus.shuffle;
        take_rank = ptr;
        if (ptr_cnt != '0) begin
          take      = 1'b1;
          state_nxt = DELIVER;
        end else if (ptr == 4'd12) begin
          // Unreachable while cards_left tracks the rank counts; never walk past the ranks.
          state_nxt = IDLE;
        end
      end
      DELIVER: begin
        shuf_set  = bus.shuffle;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      left         <= FULL_SHOE;
      lfsr         <= SEED_EFF;
      tries        <= '0;
      ptr          <= '0;
      req_pending  <= 1'b0;
      shuf_pending <= 1'b0;
      value_q      <= '0;
      for (int i = 0; i < 13; i++) rank_cnt[i] <= FULL_RANK;
    end else begin
      state <= state_nxt;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (req_set)      req_pending <= 1'b1;
      else if (req_clr) req_pending <= 1'b0;

      if (shuf_set)      shuf_pending <= 1'b1;
      else if (shuf_clr) shuf_pending <= 1'b0;

      case (state)
        IDLE: begin
          ptr   <= '0;
          tries <= '0;
        end
        SHUFFLE: begin
          for (int i = 0; i < 13; i++)
            if (ptr == 4'(i)) rank_cnt[i] <= FULL_RANK;
          ptr <= ptr + 4'd1;
          if (ptr == 4'd12) left <= FULL_SHOE;
        end
        DRAW:    tries <= tries + 4'd1;
        SCAN:    ptr   <= ptr + 4'd1;
        default: ;
      endcase

      if (take) begin
        for (int i = 0; i < 13; i++)
          if (take_rank == 4'(i)) rank_cnt[i] <= rank_cnt[i] - 1'b1;
        left    <= left - 1'b1;
        value_q <= rank_value(take_rank);
      end
    end
  end

  assign bus.ready      = (state == DELIVER);
  assign bus.busy       = (state != IDLE);
  assign bus.value      = value_q;
  assign bus.cards_left = left;
endmodule

// File: tb/tb_card_dealer.sv
// Random-gap draw sequences for card_dealer, checked against a per-value shoe model.
// The model also checks latency bounds, refill, pending-shuffle handling and reset aborts.
module tb_card_dealer;
  localparam int DECKS = 1;

  logic clk = 1'b0;
  logic rst;

  card_dealer_if #(.DECKS(DECKS)) bus ();

  card_dealer #(.DECKS(DECKS), .SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mcount [1:10];
  int mleft;
  int hist   [1:10];
  int bt     [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A full shoe holds 4 cards of each value 1..9 per deck, plus 16 ten-valued cards per deck.
  task automatic model_fill();
    for (int v = 1; v <= 9; v++) mcount[v] = 4 * DECKS;
    mcount[10] = 16 * DECKS;
    mleft      = 52 * DECKS;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready), 0);
    chk({tag, "_value"}, 32'(bus.value), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_left"},  32'(bus.cards_left), 52 * DECKS);
  endtask

  // Pulse request for one cycle and wait for ready within [lo, hi] cycles.
  // shuf_at >= 1 pulses shuffle during that cycle of the wait.
  task automatic draw(input int lo, input int hi, input int shuf_at, output logic [3:0] v);
    int k;
    bit got;
    bus.request = 1'b1;
    @(negedge clk);
    bus.request = 1'b0;
    bus.shuffle = 1'b0;
    chk("busy_rise", 32'(bus.busy), 1);
    k   = 1;
    got = 1'b0;
    v   = '0;
    while (!got && k <= hi) begin
      bt[k] = int'(bus.busy);
      if (bus.ready) begin
        got = 1'b1;
      end else begin
        bus.shuffle = (k == shuf_at);
        @(negedge clk);
        k++;
      end
    end
    bus.shuffle = 1'b0;
    chk("ready_seen", 32'(got), 1);
    if (got) begin
      v = bus.value;
      chk("latency", 32'(k >= lo && k <= hi), 1);
      chk("value_range", 32'(v >= 4'd1 && v <= 4'd10), 1);
      if (v >= 4'd1 && v <= 4'd10) begin
        chk("value_avail", 32'(mcount[v] > 0), 1);
        if (mcount[v] > 0) mcount[v]--;
        hist[v]++;
      end
      mleft--;
      chk("left_at_ready", 32'(bus.cards_left), 32'(mleft));
      @(negedge clk);
      chk("ready_one_cycle", 32'(bus.ready), 0);
      chk("value_held", 32'(bus.value), 32'(v));
      chk("idle_after", 32'(bus.busy), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int n;
    bus.request = 1'b0;
    bus.shuffle = 1'b0;
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) hist[i] = 0;
    repeat (2) @(negedge clk);
    chk_reset("reset0");
    rst = 1'b0;
    model_fill();

    // The whole shoe, with random idle gaps between requests.
    for (int i = 0; i < 52; i++) begin
      draw(2, 31, -1, v);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 1; i <= 9; i++) chk("hist_low", 32'(hist[i]), 4 * DECKS);
    chk("hist_ten", 32'(hist[10]), 16 * DECKS);
    chk("left_empty", 32'(bus.cards_left), 0);

    // A request on an empty shoe refills first, then deals.
    model_fill();
    draw(16, 50, -1, v);
    chk("empty_shuffle_last", 32'(bt[13]), 1);
    chk("empty_idle_after", 32'(bt[14]), 0);
    chk("empty_left", 32'(bus.cards_left), 51);

    for (int i = 0; i < 60 && mleft > 30; i++) begin
      draw(2, 31, -1, v);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("left_30", 32'(bus.cards_left), 30);

    // Shuffle and request in the same IDLE cycle.
    bus.shuffle = 1'b1;
    model_fill();
    draw(16, 50, -1, v);
    chk("sr_shuffle_last", 32'(bt[13]), 1);
    chk("sr_idle_after", 32'(bt[14]), 0);
    chk("sr_left", 32'(bus.cards_left), 51);

    // A shuffle during DRAW waits until the card is delivered.
    draw(2, 31, 1, v);
    @(negedge clk);
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("pend_shuffle_len", 32'(n), 13);
    chk("pend_shuffle_left", 32'(bus.cards_left), 52);
    model_fill();

    // Reset in the middle of DRAW.
    draw(2, 31, -1, v);
    draw(2, 31, -1, v);
    bus.request = 1'b1;
    @(negedge clk);
    bus.request = 1'b0;
    chk("rd_busy", 32'(bus.busy), 1);
    chk("rd_no_ready", 32'(bus.ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_draw");
    rst = 1'b0;
    model_fill();

    // Reset in the 5th SHUFFLE cycle.
    draw(2, 31, -1, v);
    draw(2, 31, -1, v);
    bus.shuffle = 1'b1;
    @(negedge clk);
    bus.shuffle = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ready) n++;
      @(negedge clk);
    end
    chk("rs_busy", 32'(bus.busy), 1);
    chk("rs_left_unchanged", 32'(bus.cards_left), 50);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_shuffle");
    chk("rs_no_ready", 32'(n), 0);
    rst = 1'b0;
    model_fill();

    draw(2, 31, -1, v);
    chk("post_reset_left", 32'(bus.cards_left), 51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
